// File: rtl/acb_pkg.sv
// acb_pkg: shared constants and FSM type for the GF(2^163) core scheduler
package acb_pkg;
  localparam int FIELD_W = 163;
  localparam int DEFAULT_TIMEOUT = 200;
  localparam logic CFG_RAW = 1'b1;
  localparam logic CFG_SQR = 1'b0;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/acb_scheduler_rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin arbiter; pointer names the preferred client on contention
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic       o_gnt,
  output logic       o_any
);
  logic r_ptr;
  always_comb begin
    o_any = |i_req;
    o_gnt = &i_req ? r_ptr : i_req[1];
  end
  // after any grant the other client becomes preferred
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= 1'b0;
    else if (i_en && o_any) r_ptr <= ~o_gnt;
  end
endmodule

// File: rtl/acb_scheduler.sv
// acb_scheduler: shares one GF(2^163) multiply/square core between two clients,
// with round-robin grant, registered core operands and a timeout watchdog
module acb_scheduler
  import acb_pkg::*;
#(
  parameter int WIDTH   = FIELD_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             mode0,
  input  logic             mode1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             core_rst,
  output logic             core_enable,
  output logic             core_cfg,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic [WIDTH-1:0] core_c,
  input  logic             core_done
);
  state_t           r_state;
  logic             r_id, r_ack0, r_ack1, r_en, r_cfg, r_abort, r_valid, r_err;
  logic [WIDTH-1:0] r_a, r_b, r_data;
  logic [CNT_W-1:0] r_wd;
  logic             w_gnt, w_any, w_idle;

  assign w_idle = r_state == IDLE;

  rr_arbiter_2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req ({req1, req0}),
    .i_en  (w_idle),
    .o_gnt (w_gnt),
    .o_any (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_id    <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_en    <= 1'b0;
      r_cfg   <= 1'b0;
      r_abort <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_data  <= '0;
      r_wd    <= '0;
    end else begin
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_en    <= 1'b0;
      r_abort <= 1'b0;
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: if (w_any) begin
          r_id    <= w_gnt;
          r_ack0  <= ~w_gnt;
          r_ack1  <= w_gnt;
          r_en    <= 1'b1;
          r_a     <= w_gnt ? a1 : a0;
          r_b     <= w_gnt ? b1 : b0;
          r_cfg   <= w_gnt ? mode1 : mode0;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_wd    <= '0;
          r_state <= WAIT;
        end
        // a done coinciding with watchdog expiry is treated as success
        WAIT: if (core_done) begin
          r_data  <= core_c;
          r_err   <= 1'b0;
          r_valid <= 1'b1;
          r_state <= RESP;
        end else if (r_wd == CNT_W'(TIMEOUT - 1)) begin
          r_abort <= 1'b1;
          r_data  <= '0;
          r_err   <= 1'b1;
          r_valid <= 1'b1;
          r_state <= RESP;
        end else begin
          r_wd <= r_wd + CNT_W'(1);
        end
        RESP: begin
          r_data  <= '0;
          r_err   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign rsp_valid   = r_valid;
  assign rsp_id      = r_valid & r_id;
  assign rsp_err     = r_err;
  assign rsp_data    = r_data;
  assign busy        = ~w_idle;
  assign core_rst    = rst | r_abort;
  assign core_enable = r_en;
  assign core_cfg    = r_cfg;
  assign core_a      = r_a;
  assign core_b      = r_b;
endmodule

// File: tb/tb_acb_scheduler.sv
// tb_acb_scheduler: randomized scoreboard bench with a GF(2^163) core model and
// a request-level reference model of the round-robin scheduler
module tb_acb_scheduler;
  import acb_pkg::*;
  localparam int W  = FIELD_W;
  localparam int TO = DEFAULT_TIMEOUT;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0, mode0 = 1'b0, mode1 = 1'b0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         ack0, ack1, rsp_valid, rsp_id, rsp_err, busy;
  logic         core_rst, core_enable, core_cfg, core_done;
  logic [W-1:0] rsp_data, core_a, core_b, core_c;

  always #5 clk = ~clk;

  acb_scheduler dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .ack0(ack0), .ack1(ack1),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .busy(busy), .core_rst(core_rst), .core_enable(core_enable), .core_cfg(core_cfg),
    .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_done(core_done)
  );

  typedef struct {
    logic         id;
    logic         err;
    logic [W-1:0] data;
    logic         cfg;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         cur;
  int           checks = 0, errors = 0, cyc = 0, last_done = -10, ack_cyc = 0, rsp_seen = 0;
  bit           in_op = 1'b0, m_ptr = 1'b0, m_early = 1'b0;
  int           m_lat = 1;
  logic [W-1:0] last_data;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // polynomial basis, reduction by x^163 + x^7 + x^6 + x^3 + 1
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] acc, sh;
    acc = '0;
    sh  = x;
    for (int i = 0; i < W; i++) begin
      if (y[i]) acc ^= sh;
      sh = sh[W-1] ? ((sh << 1) ^ W'('hC9)) : (sh << 1);
    end
    return acc;
  endfunction

  function automatic logic [W-1:0] rnd_fe();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // core model: m_lat cycles after start, 0 = never completes; m_early fakes a done in ISSUE
  logic         m_busy = 1'b0, m_done = 1'b0;
  int           m_cnt = 0;
  logic [W-1:0] m_res = '0, m_c = '0;
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (core_rst) m_busy <= 1'b0;
    else if (core_enable) begin
      m_busy <= m_lat != 0;
      m_cnt  <= m_lat;
      m_res  <= core_cfg ? gf_mul(core_a, core_b) : gf_mul(gf_mul(core_a, core_b), gf_mul(core_a, core_b));
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_done <= 1'b1;
        m_c    <= m_res;
        m_busy <= 1'b0;
      end else m_cnt <= m_cnt - 1;
    end
  end
  assign core_done = m_done | (m_early & core_enable);
  assign core_c    = (m_early & core_enable) ? {W{1'b1}} : m_c;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) assert (!(ack0 && ack1)) else $error("FAIL ack_exclusive ack0=%b ack1=%b", ack0, ack1);

  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      in_op = 1'b0;
    end else begin
      if (ack0 || ack1) begin
        check("ack_expected", W'(exp_q.size() != 0), W'(1));
        if (exp_q.size() != 0) begin
          cur = exp_q[0];
          check("ack_id", W'(ack1), W'(cur.id));
          check("issue_enable", W'(core_enable), W'(1));
          in_op   = 1'b1;
          ack_cyc = cyc;
        end
      end
      if (core_done && !ack0 && !ack1) last_done = cyc;
      if (in_op) begin
        check("core_a_hold", core_a, cur.a);
        check("core_b_hold", core_b, cur.b);
        check("core_cfg_hold", W'(core_cfg), W'(cur.cfg));
        check("busy_in_op", W'(busy), W'(1));
      end
      if (rsp_valid) begin
        rsp_seen++;
        last_data = rsp_data;
        check("rsp_expected", W'(exp_q.size() != 0), W'(1));
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_id", W'(rsp_id), W'(e.id));
          check("rsp_err", W'(rsp_err), W'(e.err));
          check("rsp_data", rsp_data, e.data);
          if (e.err) begin
            check("timeout_latency", W'(cyc - ack_cyc), W'(TO + 1));
            check("abort_core_rst", W'(core_rst), W'(1));
          end else begin
            check("done_latency", W'(cyc - last_done), W'(1));
            check("no_abort", W'(core_rst), W'(0));
          end
        end
        in_op = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, W'({ack0, ack1, rsp_valid, rsp_id, rsp_err, busy, core_enable, core_cfg, core_rst}),
          W'(9'b000000001));
    check({tag, "_rsp_data"}, rsp_data, '0);
    check({tag, "_core_a"}, core_a, '0);
    check({tag, "_core_b"}, core_b, '0);
  endtask

  task automatic push_expect(input bit g, input bit md0, input bit md1, input logic [W-1:0] x0,
                             input logic [W-1:0] y0, input logic [W-1:0] x1, input logic [W-1:0] y1,
                             input int lat);
    exp_t e;
    logic [W-1:0] p;
    e.id  = g;
    e.err = lat == 0;
    e.cfg = g ? md1 : md0;
    e.a   = g ? x1 : x0;
    e.b   = g ? y1 : y0;
    p     = gf_mul(e.a, e.b);
    e.data = e.err ? '0 : (e.cfg ? p : gf_mul(p, p));
    exp_q.push_back(e);
  endtask

  task automatic run_op(input bit r0, input bit r1, input bit md0, input bit md1,
                        input logic [W-1:0] x0, input logic [W-1:0] y0,
                        input logic [W-1:0] x1, input logic [W-1:0] y1,
                        input int lat, input bit early);
    m_lat = lat;
    m_early = early;
    req0 = r0; req1 = r1; mode0 = md0; mode1 = md1;
    a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    // contention serves the preferred client first and leaves the preference unchanged
    if (r0 && r1) begin
      push_expect(m_ptr, md0, md1, x0, y0, x1, y1, lat);
      push_expect(!m_ptr, md0, md1, x0, y0, x1, y1, lat);
    end else begin
      push_expect(r1, md0, md1, x0, y0, x1, y1, lat);
      m_ptr = !r1;
    end
    @(negedge clk); #1;
    check("ack_latency", W'(ack0 | ack1), W'(1));
    for (int c = 0; c < 1000 && exp_q.size() != 0; c++) begin
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
      @(negedge clk); #1;
    end
    check("op_drain", W'(exp_q.size()), '0);
    req0 = 1'b0;
    req1 = 1'b0;
    if (exp_q.size() != 0) begin
      rst = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0;
      m_ptr = 1'b0;
    end
    @(negedge clk); #1;
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    run_op(1, 1, 1, 1, rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe(), 20, 0);
    run_op(1, 1, 0, 1, rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe(), 15, 0);
    run_op(0, 1, 0, 0, '0, '0, rnd_fe(), rnd_fe(), 5, 0);
    run_op(0, 1, 0, 1, '0, '0, rnd_fe(), rnd_fe(), 7, 0);
    run_op(1, 0, 1, 0, W'(2), W'(3), '0, '0, 163, 0);
    check("raw_2x3", last_data, W'(6));
    run_op(1, 0, 0, 0, W'(2), W'(3), '0, '0, 163, 0);
    check("sqr_2x3", last_data, W'('h14));
    run_op(0, 1, 1, 1, '0, '0, rnd_fe(), rnd_fe(), 0, 0);
    run_op(1, 0, 1, 0, rnd_fe(), rnd_fe(), '0, '0, 12, 0);
    // reset in the middle of WAIT: the operation disappears without a response
    m_lat = 100; m_early = 1'b0;
    req0 = 1'b1; a0 = rnd_fe(); b0 = rnd_fe(); mode0 = 1'b1;
    push_expect(1'b0, 1'b1, 1'b0, a0, b0, '0, '0, 100);
    @(negedge clk); #1;
    check("ack_latency", W'(ack0), W'(1));
    req0 = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    seen = rsp_seen;
    rst = 1'b1;
    @(negedge clk); #1;
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    m_ptr = 1'b0;
    repeat (150) @(negedge clk);
    #1;
    check("reset_no_rsp", W'(rsp_seen), W'(seen));
    run_op(1, 0, 1, 0, rnd_fe(), rnd_fe(), '0, '0, 10, 1);
    run_op(0, 1, 0, 0, '0, '0, rnd_fe(), rnd_fe(), 10, 1);
    for (int n = 0; n < 24; n++) begin
      int pat, lat;
      pat = $urandom_range(1, 3);
      lat = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 40);
      run_op(pat[0], pat[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             rnd_fe(), rnd_fe(), rnd_fe(), rnd_fe(), lat, $urandom_range(0, 3) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
